// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-control types: sequencing states and forwarding select encodings.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } pipe_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding compare for one EX operand: MEM result beats WB result, register 0 never forwarded.
module fwd_unit
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] srcReg,
  input  logic            memRegWrite,
  input  logic [RA_W-1:0] memWriteReg,
  input  logic            wbRegWrite,
  input  logic [RA_W-1:0] wbWriteReg,
  output logic [1:0]      fwdSel
);

  // Priority select of the youngest producer of srcReg
  always_comb begin
    fwdSel = FWD_RF;
    if (memRegWrite && (memWriteReg != '0) && (memWriteReg == srcReg)) begin
      fwdSel = FWD_MEM;
    end else if (wbRegWrite && (wbWriteReg != '0) && (wbWriteReg == srcReg)) begin
      fwdSel = FWD_WB;
    end
  end

endmodule

// File: rtl/idex_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, taken-branch flush, dmem-wait freeze,
// EX operand forwarding and a saturating stall-cycle counter.
module idex_hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned RA_W        = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rt,
  input  logic [RA_W-1:0]  ex_rs,
  input  logic [RA_W-1:0]  ex_rt,
  input  logic             ex_mem_read,
  input  logic [RA_W-1:0]  ex_write_reg,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic             mem_reg_write,
  input  logic [RA_W-1:0]  mem_write_reg,
  input  logic             wb_reg_write,
  input  logic [RA_W-1:0]  wb_write_reg,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

  pipe_state_e     state, nextState;
  logic [WC_W-1:0] waitCnt, nextWaitCnt;
  logic            setTimeout;
  logic            loadUse;
  logic            pcW, ifidW, ifidF, idexH, idexB, exmemH;
  logic [1:0]      fwdARaw, fwdBRaw;

  assign loadUse = ex_mem_read && (ex_write_reg != '0) &&
                   ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));

  fwd_unit #(.RA_W(RA_W)) u_fwd_a (
    .srcReg      (ex_rs),
    .memRegWrite (mem_reg_write),
    .memWriteReg (mem_write_reg),
    .wbRegWrite  (wb_reg_write),
    .wbWriteReg  (wb_write_reg),
    .fwdSel      (fwdARaw)
  );

  fwd_unit #(.RA_W(RA_W)) u_fwd_b (
    .srcReg      (ex_rt),
    .memRegWrite (mem_reg_write),
    .memWriteReg (mem_write_reg),
    .wbRegWrite  (wb_reg_write),
    .wbWriteReg  (wb_write_reg),
    .fwdSel      (fwdBRaw)
  );

  // State, wait counter, sticky timeout and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      waitCnt      <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
      if (setTimeout) mem_timeout <= 1'b1;
      if (!pcW && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  // Next-state and control decode; RUN-style decode is reused on MEM_WAIT release
  always_comb begin
    nextState   = state;
    nextWaitCnt = waitCnt;
    setTimeout  = 1'b0;
    pcW         = 1'b0;
    ifidW       = 1'b0;
    ifidF       = 1'b0;
    idexH       = 1'b0;
    idexB       = 1'b0;
    exmemH      = 1'b0;
    case (state)
      RUN, MEM_WAIT: begin
        if (!dmem_ready && ((state == MEM_WAIT) || mem_access)) begin
          idexH  = 1'b1;
          exmemH = 1'b1;
          if (state == RUN) begin
            nextState   = MEM_WAIT;
            nextWaitCnt = WC_W'(1);
          end else begin
            nextWaitCnt = waitCnt + WC_W'(1);
            if (nextWaitCnt >= WC_W'(MEM_TIMEOUT - 1)) begin
              setTimeout = 1'b1;
              nextState  = ERROR;
            end
          end
        end else begin
          nextState   = RUN;
          nextWaitCnt = '0;
          if (branch_taken) begin
            // Wrong-path instructions are squashed; the load-use stall is moot
            pcW   = 1'b1;
            ifidW = 1'b1;
            ifidF = 1'b1;
            idexB = 1'b1;
          end else if (loadUse) begin
            idexB = 1'b1;
          end else begin
            pcW   = 1'b1;
            ifidW = 1'b1;
          end
        end
      end
      ERROR: begin
        idexH  = 1'b1;
        exmemH = 1'b1;
      end
      default: nextState = RUN;
    endcase
  end

  // Outputs forced to their reset values while rst_n is low
  assign pc_write    = rst_n & pcW;
  assign ifid_write  = rst_n & ifidW;
  assign ifid_flush  = ~rst_n | ifidF;
  assign idex_hold   = rst_n & idexH;
  assign idex_bubble = ~rst_n | idexB;
  assign exmem_hold  = rst_n & exmemH;
  assign fwd_a       = rst_n ? fwdARaw : FWD_RF;
  assign fwd_b       = rst_n ? fwdBRaw : FWD_RF;

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Directed bench for idex_hazard_ctrl (CNT_W reduced to 4 so saturation is reachable).
module tb_idex_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
  logic       id_uses_rt, ex_mem_read, branch_taken, mem_access, dmem_ready;
  logic       mem_reg_write, wb_reg_write;
  logic       pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble, exmem_hold, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  idex_hazard_ctrl #(.RA_W(5), .MEM_TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
    .branch_taken(branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_hold(idex_hold), .idex_bubble(idex_bubble), .exmem_hold(exmem_hold),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0;
    ex_mem_read = 0; ex_write_reg = 0; branch_taken = 0;
    mem_access = 0; dmem_ready = 1;
    mem_reg_write = 0; mem_write_reg = 0; wb_reg_write = 0; wb_write_reg = 0;
  endtask

  // Inputs are driven 1 time unit after the rising edge; checks happen 2 units later
  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearIn();
    rst_n = 1'b0;
    // Forwarding request present during reset must be suppressed
    ex_rs = 5'd5; mem_reg_write = 1; mem_write_reg = 5'd5;
    #12;
    chk("rst_pc_write", 32'(pc_write), 0);
    chk("rst_ifid_write", 32'(ifid_write), 0);
    chk("rst_ifid_flush", 32'(ifid_flush), 1);
    chk("rst_idex_bubble", 32'(idex_bubble), 1);
    chk("rst_idex_hold", 32'(idex_hold), 0);
    chk("rst_exmem_hold", 32'(exmem_hold), 0);
    chk("rst_fwd_a", 32'(fwd_a), 0);
    chk("rst_timeout", 32'(mem_timeout), 0);
    chk("rst_stall", 32'(stall_cycles), 0);
    rst_n = 1'b1;
    clearIn();
    nextCyc(); #2;
    chk("run_pc_write", 32'(pc_write), 1);
    chk("run_bubble", 32'(idex_bubble), 0);

    // lw $2 in EX, add $3,$2,$4 in ID: one bubble
    nextCyc();
    ex_mem_read = 1; ex_write_reg = 5'd2; id_rs = 5'd2; id_rt = 5'd4; id_uses_rt = 1;
    #2;
    chk("lu_pc_write", 32'(pc_write), 0);
    chk("lu_ifid_write", 32'(ifid_write), 0);
    chk("lu_bubble", 32'(idex_bubble), 1);
    chk("lu_hold", 32'(idex_hold), 0);
    // Next cycle: add in EX, lw in MEM
    nextCyc();
    clearIn();
    ex_rs = 5'd2; ex_rt = 5'd4; mem_reg_write = 1; mem_write_reg = 5'd2;
    #2;
    chk("lu_next_fwd_a", 32'(fwd_a), 32'h2);
    chk("lu_next_fwd_b", 32'(fwd_b), 0);
    chk("lu_next_pc_write", 32'(pc_write), 1);
    chk("lu_stall_cnt", 32'(stall_cycles), 1);

    // rt match ignored when the ID instruction does not read rt
    nextCyc();
    clearIn();
    ex_mem_read = 1; ex_write_reg = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 0;
    #2;
    chk("lu_rt_unused", 32'(pc_write), 1);
    id_uses_rt = 1;
    #1;
    chk("lu_rt_used", 32'(pc_write), 0);
    // Load to $0 never stalls
    nextCyc();
    clearIn();
    ex_mem_read = 1; ex_write_reg = 5'd0; id_rs = 5'd0;
    #2;
    chk("lu_r0", 32'(pc_write), 1);

    // load-use and taken branch together: flush, no stall
    nextCyc();
    clearIn();
    ex_mem_read = 1; ex_write_reg = 5'd2; id_rs = 5'd2; branch_taken = 1;
    #2;
    chk("br_flush", 32'(ifid_flush), 1);
    chk("br_bubble", 32'(idex_bubble), 1);
    chk("br_pc_write", 32'(pc_write), 1);
    nextCyc();
    clearIn();
    #2;
    chk("br_stall_cnt", 32'(stall_cycles), 2);

    // dmem wait for 3 cycles with a pending taken branch, release on 4th
    for (int i = 0; i < 3; i++) begin
      nextCyc();
      clearIn();
      mem_access = 1; dmem_ready = 0; branch_taken = 1;
      #2;
      chk($sformatf("mw_pc_write_%0d", i), 32'(pc_write), 0);
      chk($sformatf("mw_idex_hold_%0d", i), 32'(idex_hold), 1);
      chk($sformatf("mw_exmem_hold_%0d", i), 32'(exmem_hold), 1);
      chk($sformatf("mw_flush_%0d", i), 32'(ifid_flush), 0);
    end
    nextCyc();
    dmem_ready = 1;
    #2;
    chk("mw_rel_pc_write", 32'(pc_write), 1);
    chk("mw_rel_flush", 32'(ifid_flush), 1);
    chk("mw_rel_hold", 32'(exmem_hold), 0);
    nextCyc();
    clearIn();
    #2;
    chk("mw_stall_cnt", 32'(stall_cycles), 5);
    chk("mw_back_run", 32'(pc_write), 1);

    // Forwarding priority and register-0 exclusion
    nextCyc();
    clearIn();
    ex_rs = 5'd5; mem_reg_write = 1; mem_write_reg = 5'd5; wb_reg_write = 1; wb_write_reg = 5'd5;
    #2;
    chk("fwd_mem_beats_wb", 32'(fwd_a), 32'h2);
    nextCyc();
    clearIn();
    ex_rt = 5'd5; mem_reg_write = 1; mem_write_reg = 5'd6; wb_reg_write = 1; wb_write_reg = 5'd5;
    #2;
    chk("fwd_b_wb", 32'(fwd_b), 32'h1);
    chk("fwd_a_none", 32'(fwd_a), 0);
    nextCyc();
    clearIn();
    ex_rs = 5'd0; mem_reg_write = 1; mem_write_reg = 5'd0; wb_reg_write = 1; wb_write_reg = 5'd0;
    #2;
    chk("fwd_r0", 32'(fwd_a), 0);
    nextCyc();
    clearIn();
    ex_rs = 5'd9; mem_write_reg = 5'd9; wb_write_reg = 5'd9;
    #2;
    chk("fwd_no_write", 32'(fwd_a), 0);

    // dmem never ready: timeout after 15 wait cycles, then ERROR until reset
    for (int i = 0; i < 15; i++) begin
      nextCyc();
      clearIn();
      mem_access = 1; dmem_ready = 0;
      #2;
      chk($sformatf("to_pending_%0d", i), 32'(mem_timeout), 0);
    end
    nextCyc();
    dmem_ready = 1; mem_access = 0;
    #2;
    chk("to_set", 32'(mem_timeout), 1);
    chk("err_pc_write", 32'(pc_write), 0);
    chk("err_exmem_hold", 32'(exmem_hold), 1);
    for (int i = 0; i < 3; i++) nextCyc();
    #2;
    chk("err_still_timeout", 32'(mem_timeout), 1);
    chk("err_still_frozen", 32'(idex_hold), 1);
    chk("stall_saturated", 32'(stall_cycles), 15);

    // Reset clears ERROR
    rst_n = 1'b0;
    #1;
    chk("rst2_timeout", 32'(mem_timeout), 0);
    chk("rst2_stall", 32'(stall_cycles), 0);
    rst_n = 1'b1;
    clearIn();

    // Reset pulsed off-edge in the middle of MEM_WAIT
    for (int i = 0; i < 2; i++) begin
      nextCyc();
      mem_access = 1; dmem_ready = 0;
    end
    #2;
    chk("mid_frozen", 32'(exmem_hold), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc_write", 32'(pc_write), 0);
    chk("mid_rst_flush", 32'(ifid_flush), 1);
    chk("mid_rst_bubble", 32'(idex_bubble), 1);
    chk("mid_rst_exmem_hold", 32'(exmem_hold), 0);
    chk("mid_rst_idex_hold", 32'(idex_hold), 0);
    chk("mid_rst_stall", 32'(stall_cycles), 0);
    #1;
    rst_n = 1'b1;
    clearIn();
    #1;
    chk("mid_rel_run", 32'(pc_write), 1);
    nextCyc();
    mem_access = 1; dmem_ready = 1;
    #2;
    chk("mid_no_pending", 32'(pc_write), 1);
    chk("mid_no_hold", 32'(exmem_hold), 0);
    chk("mid_stall_zero", 32'(stall_cycles), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
